// File: rtl/alu_integer_seq.sv
// Registered integer ALU. Single-cycle ops complete one cycle after acceptance;
// multiply/divide/remainder iterate one bit per cycle behind a START/BUSY/DONE handshake.
module alu_integer_seq #(
  parameter int unsigned Width      = 32,
  parameter int unsigned ExtensionI = 0
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic [4:0]       SEL,
  input  logic [Width-1:0] RS1,
  input  logic [Width-1:0] RS2,
  output logic             BUSY,
  output logic             DONE,
  output logic [Width-1:0] RD
);

  localparam int unsigned ShW   = $clog2(Width);
  localparam bit          MulEn = (ExtensionI == 1) || (ExtensionI == 2);
  localparam bit          DivEn = (ExtensionI == 1);

  localparam logic [4:0] OpAdd  = 5'd0;
  localparam logic [4:0] OpSll  = 5'd1;
  localparam logic [4:0] OpSlt  = 5'd2;
  localparam logic [4:0] OpSltu = 5'd3;
  localparam logic [4:0] OpXor  = 5'd4;
  localparam logic [4:0] OpSrl  = 5'd5;
  localparam logic [4:0] OpOr   = 5'd6;
  localparam logic [4:0] OpAnd  = 5'd7;
  localparam logic [4:0] OpSub  = 5'd8;
  localparam logic [4:0] OpBeq  = 5'd12;
  localparam logic [4:0] OpSra  = 5'd13;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_e;

  state_e             state_q, state_d;
  logic [Width-1:0]   rd_q, rd_d;
  logic [Width-1:0]   b_q, b_d;        // multiplicand or divisor magnitude
  logic [2*Width-1:0] prod_q, prod_d;  // {hi, lo}: product, or {remainder, dividend/quotient}
  logic [ShW-1:0]     cnt_q, cnt_d;
  logic [4:0]         op_q, op_d;
  logic               neg_q, neg_d;    // product / quotient sign
  logic               rneg_q, rneg_d;  // remainder sign
  logic               done_q, done_d;

  logic [ShW-1:0]     shamt;
  logic               is_mul, is_div, s1_sgn, s2_sgn, a_neg, b_neg, ovf;
  logic [Width-1:0]   abs_a, abs_b, base_res, quo, rem;
  logic [Width:0]     mul_sum, div_shift, div_diff;
  logic [2*Width-1:0] prod_fix;

  // Operand decode, magnitudes and single-cycle results
  always_comb begin
    shamt  = RS2[ShW-1:0];
    is_mul = MulEn && (SEL[4:2] == 3'b110);
    is_div = DivEn && (SEL[4:2] == 3'b111);
    // Divide ops: signed when SEL[0]=0; multiplies: RS1 signed unless MULHU, RS2 only for MUL/MULH
    s1_sgn = SEL[2] ? !SEL[0] : (SEL[1:0] != 2'b11);
    s2_sgn = SEL[2] ? !SEL[0] : !SEL[1];
    a_neg  = s1_sgn && RS1[Width-1];
    b_neg  = s2_sgn && RS2[Width-1];
    abs_a  = a_neg ? -RS1 : RS1;
    abs_b  = b_neg ? -RS2 : RS2;
    ovf    = s1_sgn && (RS1 == {1'b1, {(Width-1){1'b0}}}) && (&RS2);
    case (SEL)
      OpAdd:   base_res = RS1 + RS2;
      OpSll:   base_res = RS1 << shamt;
      OpSlt:   base_res = {{(Width-1){1'b0}}, $signed(RS1) < $signed(RS2)};
      OpSltu:  base_res = {{(Width-1){1'b0}}, RS1 < RS2};
      OpXor:   base_res = RS1 ^ RS2;
      OpSrl:   base_res = RS1 >> shamt;
      OpOr:    base_res = RS1 | RS2;
      OpAnd:   base_res = RS1 & RS2;
      OpSub:   base_res = RS1 - RS2;
      OpBeq:   base_res = {{(Width-1){1'b0}}, RS1 == RS2};
      OpSra:   base_res = $signed(RS1) >>> shamt;
      default: base_res = '0;
    endcase
  end

  // Iteration datapath: shift-add multiply step, restoring divide step, sign fix-up
  always_comb begin
    mul_sum   = {1'b0, prod_q[2*Width-1:Width]} + (prod_q[0] ? {1'b0, b_q} : '0);
    div_shift = {prod_q[2*Width-1:Width], prod_q[Width-1]};
    div_diff  = div_shift - {1'b0, b_q};
    prod_fix  = neg_q ? -prod_q : prod_q;
    quo       = neg_q ? -prod_q[Width-1:0] : prod_q[Width-1:0];
    rem       = rneg_q ? -prod_q[2*Width-1:Width] : prod_q[2*Width-1:Width];
  end

  // Next-state and result selection
  always_comb begin
    state_d = state_q;
    rd_d    = rd_q;
    b_d     = b_q;
    prod_d  = prod_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    neg_d   = neg_q;
    rneg_d  = rneg_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (START) begin
          op_d  = SEL;
          cnt_d = '0;
          if (is_mul) begin
            b_d     = abs_a;
            prod_d  = {{Width{1'b0}}, abs_b};
            neg_d   = a_neg ^ b_neg;
            state_d = S_MUL;
          end else if (is_div) begin
            if (RS2 == '0) begin
              rd_d   = SEL[1] ? RS1 : '1;
              done_d = 1'b1;
            end else if (ovf) begin
              rd_d   = SEL[1] ? '0 : RS1;
              done_d = 1'b1;
            end else begin
              b_d     = abs_b;
              prod_d  = {{Width{1'b0}}, abs_a};
              neg_d   = a_neg ^ b_neg;
              rneg_d  = a_neg;
              state_d = S_DIV;
            end
          end else begin
            rd_d   = base_res;
            done_d = 1'b1;
          end
        end
      end
      S_MUL: begin
        prod_d = {mul_sum, prod_q[Width-1:1]};
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == ShW'(Width - 1)) state_d = S_FIX;
      end
      S_DIV: begin
        if (!div_diff[Width]) begin
          prod_d = {div_diff[Width-1:0], prod_q[Width-2:0], 1'b1};
        end else begin
          prod_d = {div_shift[Width-1:0], prod_q[Width-2:0], 1'b0};
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == ShW'(Width - 1)) state_d = S_FIX;
      end
      S_FIX: begin
        state_d = S_IDLE;
        done_d  = 1'b1;
        if (op_q[2]) begin
          rd_d = op_q[1] ? rem : quo;
        end else begin
          rd_d = (op_q[1:0] == 2'b00) ? prod_fix[Width-1:0] : prod_fix[2*Width-1:Width];
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= S_IDLE;
      rd_q    <= '0;
      b_q     <= '0;
      prod_q  <= '0;
      cnt_q   <= '0;
      op_q    <= '0;
      neg_q   <= 1'b0;
      rneg_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rd_q    <= rd_d;
      b_q     <= b_d;
      prod_q  <= prod_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      neg_q   <= neg_d;
      rneg_q  <= rneg_d;
      done_q  <= done_d;
    end
  end

  // Outputs
  always_comb begin
    BUSY = (state_q != S_IDLE);
    DONE = done_q;
    RD   = rd_q;
  end

endmodule

// File: tb/tb_alu_integer_seq.sv
// Scoreboard bench for alu_integer_seq: three instances cover ExtensionI = 0, 1, 2.
module tb_alu_integer_seq;

  typedef struct {
    logic [31:0] rd;
    int          cyc;
    int          busy;
    string       name;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start [3];
  logic [4:0]  sel   [3];
  logic [31:0] rs1   [3];
  logic [31:0] rs2   [3];
  logic        busy  [3];
  logic        done  [3];
  logic [31:0] rd    [3];

  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  int   busy_run [3];
  exp_t q0[$], q1[$], q2[$];
  exp_t mon_e;
  bit   mon_ok;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  alu_integer_seq #(.Width(32), .ExtensionI(0)) u_ext0 (
    .CLK(clk), .RST(rst), .START(start[0]), .SEL(sel[0]), .RS1(rs1[0]), .RS2(rs2[0]),
    .BUSY(busy[0]), .DONE(done[0]), .RD(rd[0])
  );
  alu_integer_seq #(.Width(32), .ExtensionI(1)) u_ext1 (
    .CLK(clk), .RST(rst), .START(start[1]), .SEL(sel[1]), .RS1(rs1[1]), .RS2(rs2[1]),
    .BUSY(busy[1]), .DONE(done[1]), .RD(rd[1])
  );
  alu_integer_seq #(.Width(32), .ExtensionI(2)) u_ext2 (
    .CLK(clk), .RST(rst), .START(start[2]), .SEL(sel[2]), .RS1(rs1[2]), .RS2(rs2[2]),
    .BUSY(busy[2]), .DONE(done[2]), .RD(rd[2])
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", name, act, exp);
    end
  endtask

  task automatic push_exp(input int k, input exp_t e);
    case (k)
      0:       q0.push_back(e);
      1:       q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  task automatic pop_exp(input int k, output exp_t e, output bit ok);
    ok = 1'b0;
    case (k)
      0:       if (q0.size() > 0) begin e = q0.pop_front(); ok = 1'b1; end
      1:       if (q1.size() > 0) begin e = q1.pop_front(); ok = 1'b1; end
      default: if (q2.size() > 0) begin e = q2.pop_front(); ok = 1'b1; end
    endcase
  endtask

  // Called just after a rising edge; returns in the cycle the result is due.
  task automatic issue(input int k, input string name, input logic [4:0] s,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp_rd, input bit iter);
    int   lat;
    exp_t e;
    lat    = iter ? 34 : 1;
    e.rd   = exp_rd;
    e.cyc  = cyc + lat;
    e.busy = iter ? 33 : 0;
    e.name = name;
    push_exp(k, e);
    start[k] = 1'b1;
    sel[k]   = s;
    rs1[k]   = a;
    rs2[k]   = b;
    @(posedge clk);
    #1;
    start[k] = 1'b0;
    if (lat > 1) begin
      repeat (lat - 1) @(posedge clk);
      #1;
    end
  endtask

  // Monitor: every DONE pops one expectation and checks value, timing and busy span
  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (!rst) begin
        busy_run[k] = 0;
      end else begin
        if (busy[k]) busy_run[k] = busy_run[k] + 1;
        if (done[k]) begin
          pop_exp(k, mon_e, mon_ok);
          if (!mon_ok) begin
            total++;
            bad++;
            $display("FAIL unexpected_done inst=%0d got rd=%h want no DONE", k, rd[k]);
          end else begin
            check({mon_e.name, "_rd"}, rd[k], mon_e.rd);
            check({mon_e.name, "_cycle"}, cyc, mon_e.cyc);
            check({mon_e.name, "_busy"}, busy_run[k], mon_e.busy);
          end
          busy_run[k] = 0;
        end
      end
    end
  end

  initial begin
    for (int k = 0; k < 3; k++) begin
      start[k]    = 1'b0;
      sel[k]      = 5'd0;
      rs1[k]      = 32'd0;
      rs2[k]      = 32'd0;
      busy_run[k] = 0;
    end
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("reset_rd%0d", k), rd[k], 32'd0);
      check($sformatf("reset_busy%0d", k), {31'd0, busy[k]}, 32'd0);
      check($sformatf("reset_done%0d", k), {31'd0, done[k]}, 32'd0);
    end
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Base ops, back to back
    issue(1, "add",  5'd0,  32'd5,          32'd7,          32'd12,         1'b0);
    issue(1, "sra",  5'd13, 32'h8000_0000,  32'd4,          32'hF800_0000,  1'b0);
    issue(1, "sub",  5'd8,  32'd3,          32'd5,          32'hFFFF_FFFE,  1'b0);
    issue(1, "slt",  5'd2,  32'hFFFF_FFFF,  32'd1,          32'd1,          1'b0);
    issue(1, "sltu", 5'd3,  32'hFFFF_FFFF,  32'd1,          32'd0,          1'b0);
    issue(1, "beq",  5'd12, 32'd9,          32'd9,          32'd1,          1'b0);
    issue(1, "sll",  5'd1,  32'd1,          32'd31,         32'h8000_0000,  1'b0);
    issue(1, "srl",  5'd5,  32'h8000_0000,  32'd36,         32'h0800_0000,  1'b0);
    issue(1, "xor",  5'd4,  32'h0000_F0F0,  32'h0000_FF00,  32'h0000_0FF0,  1'b0);
    issue(1, "or",   5'd6,  32'h0000_F0F0,  32'h0000_FF00,  32'h0000_FFF0,  1'b0);
    issue(1, "and",  5'd7,  32'h0000_F0F0,  32'h0000_FF00,  32'h0000_F000,  1'b0);
    issue(1, "idle", 5'd16, 32'd5,          32'd7,          32'd0,          1'b0);
    issue(1, "undef",5'd20, 32'd5,          32'd7,          32'd0,          1'b0);

    // Multiplies
    issue(1, "mul",    5'd24, 32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFEB, 1'b1);
    issue(1, "mulhu",  5'd27, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b1);
    issue(1, "mulhsu", 5'd26, 32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFF, 1'b1);
    issue(1, "mulh",   5'd25, 32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFFF, 1'b1);
    issue(1, "mulhmin",5'd25, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 1'b1);

    // Divides
    issue(1, "div",   5'd28, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 1'b1);
    issue(1, "rem",   5'd30, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 1'b1);
    issue(1, "divu",  5'd29, 32'd100,       32'd7,         32'd14,        1'b1);
    issue(1, "remu",  5'd31, 32'd100,       32'd7,         32'd2,         1'b1);
    issue(1, "divnd", 5'd28, 32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 1'b1);
    issue(1, "remnd", 5'd30, 32'd7,         32'hFFFF_FFFE, 32'd1,         1'b1);
    issue(1, "divubig",5'd29,32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1'b1);

    // Corner cases: no iteration
    issue(1, "div0",   5'd28, 32'd5,         32'd0,         32'hFFFF_FFFF, 1'b0);
    issue(1, "rem0",   5'd30, 32'd5,         32'd0,         32'd5,         1'b0);
    issue(1, "divu0",  5'd29, 32'd5,         32'd0,         32'hFFFF_FFFF, 1'b0);
    issue(1, "remu0",  5'd31, 32'd5,         32'd0,         32'd5,         1'b0);
    issue(1, "divovf", 5'd28, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0);
    issue(1, "removf", 5'd30, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1'b0);

    // START during a multiply in flight is ignored
    issue(1, "mulhpre", 5'd25, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 1'b1);
    begin
      exp_t e;
      e.rd   = 32'd42;
      e.cyc  = cyc + 34;
      e.busy = 33;
      e.name = "mul_ign";
      push_exp(1, e);
    end
    start[1] = 1'b1; sel[1] = 5'd24; rs1[1] = 32'd6; rs2[1] = 32'd7;
    @(posedge clk);
    #1;
    start[1] = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    start[1] = 1'b1; sel[1] = 5'd0; rs1[1] = 32'd1; rs2[1] = 32'd2;
    @(posedge clk);
    #1;
    start[1] = 1'b0;
    check("ign_rd", rd[1], 32'h4000_0000);
    check("ign_done", {31'd0, done[1]}, 32'd0);
    check("ign_busy", {31'd0, busy[1]}, 32'd1);
    repeat (27) @(posedge clk);
    #1;

    // Reset in the middle of a divide aborts it silently
    start[1] = 1'b1; sel[1] = 5'd29; rs1[1] = 32'd100; rs2[1] = 32'd7;
    @(posedge clk);
    #1;
    start[1] = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("abort_rd", rd[1], 32'd0);
    check("abort_busy", {31'd0, busy[1]}, 32'd0);
    check("abort_done", {31'd0, done[1]}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    check("abort_rd_hold", rd[1], 32'd0);
    issue(1, "add_after", 5'd0, 32'd20, 32'd22, 32'd42, 1'b0);

    // Feature levels
    issue(2, "e2_div", 5'd28, 32'd7, 32'd2, 32'd0,  1'b0);
    issue(2, "e2_mul", 5'd24, 32'd6, 32'd7, 32'd42, 1'b1);
    issue(0, "e0_mul", 5'd24, 32'd6, 32'd7, 32'd0,  1'b0);
    issue(0, "e0_sel20", 5'd20, 32'd6, 32'd7, 32'd0, 1'b0);
    issue(0, "e0_add", 5'd0,  32'd1, 32'd2, 32'd3,  1'b0);

    repeat (5) @(posedge clk);
    #1;
    check("drain", 32'(q0.size() + q1.size() + q2.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_integer_seq.md
# alu_integer_seq

Registered, multi-cycle successor to the processor's combinational integer ALU. It keeps the same 5-bit operation encoding and the same `ExtensionI` feature levels. Single-cycle operations are registered with one cycle of latency. Multiply, divide and remainder run as a radix-2 iterative datapath behind a START/BUSY/DONE handshake, which removes the wide combinational multiplier and divider from the execute stage. The block sits in the processor execute stage, and the pipeline control stalls on BUSY.

## Interface
Parameters:
- `Width`, 32: operand/result width; ≥ 8, power of two; shift amount uses RS2[log2(Width)-1:0].
- `ExtensionI`, 0: 0 = base ops only; 1 = full RV32M (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU); 2 = multiplies only.

Ports:
- `CLK`  in  1  single clock, rising edge.
- `RST`  in  1  asynchronous, active-low reset.
- `START`  in  1  operation request; sampled only when BUSY=0.
- `SEL`  in  5  opcode: ADD=0, SLL=1, SLT=2, SLTU=3, XOR=4, SRL=5, OR=6, AND=7, SUB=8, BEQ=12, SRA=13, IDLE=16, MUL=24, MULH=25, MULHSU=26, MULHU=27, DIV=28, DIVU=29, REM=30, REMU=31.
- `RS1`, `RS2`  in  Width  operands; captured on the accepting edge, so they need not be held afterwards.
- `BUSY`  out  1  an iterative operation is in flight.
- `DONE`  out  1  one-cycle pulse; RD is valid in this cycle.
- `RD`  out  Width  result register; holds its value until the next DONE.

## Operation
- FSM states: S_IDLE, S_MUL, S_DIV, S_FIX.
- Reset values: state S_IDLE, RD=0, BUSY=0, DONE=0, iteration counter 0.
- **S_IDLE:**
  - START=1 with a base op, IDLE, an op not enabled by ExtensionI, or an undefined SEL: RD gets the result (0 for IDLE, disabled or undefined ops), DONE=1 next cycle, and the FSM stays in S_IDLE.
  - START=1 with a multiply: latch |RS1| and |RS2| per signedness and record the result sign, then go to S_MUL.
    - MUL and MULH: both operands signed.
    - MULHSU: RS1 signed, RS2 unsigned.
    - MULHU: both unsigned.
  - START=1 with a divide or remainder: latch magnitudes and signs, then go to S_DIV.
    - DIV and REM are signed; DIVU and REMU are unsigned.
    - Divisor = 0: no iteration. DONE next cycle with RD = all ones for DIV/DIVU, or RD = RS1 for REM/REMU.
    - Signed overflow (RS1 = most-negative, RS2 = -1): no iteration. DONE next cycle with RD = RS1 for DIV, or RD = 0 for REM.
- **S_MUL:** shift-add over Width iterations into a 2·Width product register; counter increments each cycle. After iteration Width-1, go to S_FIX.
- **S_DIV:** restoring division, one quotient bit per cycle over Width iterations; then go to S_FIX.
- **S_FIX:** apply sign correction and select the result, then go to S_IDLE with DONE=1 and RD loaded.
  - Product sign = XOR of the operand signs that apply.
  - Quotient sign = sign(RS1) XOR sign(RS2).
  - Remainder takes the sign of RS1.
  - Result select: MUL → low Width bits; MULH/MULHSU/MULHU → high Width bits; DIV/DIVU → quotient; REM/REMU → remainder.
- Base op definitions:
  - SLT/SLTU/BEQ return 1 or 0, zero-extended.
  - SRA sign-fills from RS1[Width-1].
  - Add, subtract and shifts wrap modulo 2^Width.
- BUSY=1 throughout S_MUL, S_DIV and S_FIX. START while BUSY=1 is ignored: not queued, and SEL/RS1/RS2 are don't-care.
- Reset asserted mid-operation aborts immediately: state S_IDLE, BUSY=0, RD=0, and DONE is never emitted for the aborted op.

## Timing
- Accepting edge = first rising CLK edge with START=1 and BUSY=0 (cycle t).
- Base ops, disabled ops, divide-by-zero and overflow: DONE and RD valid in cycle t+1; BUSY stays 0. Back-to-back START every cycle is allowed.
- Multiply and divide: BUSY=1 in cycles t+1 … t+Width+1; DONE and RD valid in cycle t+Width+2, when BUSY=0.
  - Latency = Width+2 cycles (34 cycles at Width=32).
  - A new START is accepted in the same cycle as DONE.
- DONE is always exactly one cycle wide. RD changes only on the edge that raises DONE, or on reset.
- RST deassertion takes effect at the next CLK edge; no START is accepted while RST=0.

## Test plan
- Reset/basic: RST low mid-run, then START ADD with RS1=5, RS2=7 → RD=0 during reset; then DONE at t+1 with RD=12. SRA with RS1=0x80000000, RS2=4 → RD=0xF8000000.
- Multiply (ExtensionI=1):
  - MUL with RS1=-3, RS2=7 → RD=0xFFFFFFEB, DONE at t+34, BUSY high for 33 cycles.
  - MULHU with RS1=RS2=0xFFFFFFFF → RD=0xFFFFFFFE.
  - MULHSU with RS1=-1, RS2=2 → RD=0xFFFFFFFF.
- Divide signs (ExtensionI=1):
  - DIV with RS1=-7, RS2=2 → RD=0xFFFFFFFD (-3).
  - REM with RS1=-7, RS2=2 → RD=0xFFFFFFFF (-1).
  - DIVU with RS1=100, RS2=7 → RD=14.
  - REMU with RS1=100, RS2=7 → RD=2.
- Corner cases (ExtensionI=1):
  - DIV with RS1=5, RS2=0 → RD=0xFFFFFFFF at t+1.
  - REM with RS1=5, RS2=0 → RD=5 at t+1.
  - DIV with RS1=0x80000000, RS2=-1 → RD=0x80000000 at t+1.
  - REM with RS1=0x80000000, RS2=-1 → RD=0.
- Handshake:
  - START ADD during a MUL in flight → ignored; RD and DONE unaffected.
  - RST low at cycle t+10 of a DIV → no DONE, RD=0; the next ADD completes normally.
- Feature levels:
  - ExtensionI=2, DIV → RD=0 at t+1 with BUSY never high.
  - ExtensionI=0, MUL → RD=0 at t+1.
  - ExtensionI=0, SEL=20 → RD=0 at t+1.
